// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone initiator: one read/write command in, one classic bus cycle
// with timeout, one response out. Define WB_CMD_MASTER_STATS_EN to add a saturating timeout counter.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter logic [7:0]  ERR_DATA       = 8'hFF
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [4:0] cmd_adr,
  input  logic [7:0] cmd_dat,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_dat,
  output logic       rsp_err,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [4:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
`ifdef WB_CMD_MASTER_STATS_EN
  ,
  output logic [7:0] err_count
`endif
);

  // One-hot so every handshake/bus strobe output is a single state flop.
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_BUS  = 3'b010,
    S_RSP  = 3'b100
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_nxt;
  logic       we_q;
  logic [4:0] adr_q;
  logic [7:0] dat_q;
  logic [7:0] rsp_dat_q;
  logic       rsp_err_q;
  logic [7:0] tmo_cnt;
  logic       bus_ack;
  logic       bus_tmo;

  // Ack is only meaningful in BUS; the slave's lingering ack after stb falls lands in RSP.
  assign bus_ack = (state == S_BUS) && wb_ack_i;
  assign bus_tmo = (state == S_BUS) && !wb_ack_i && (tmo_cnt == TMO_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nxt = S_BUS;
      S_BUS:   if (bus_ack || bus_tmo) state_nxt = S_RSP;
      S_RSP:   if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == S_IDLE);
    rsp_valid = (state == S_RSP);
    wb_cyc_o  = (state == S_BUS);
    wb_stb_o  = (state == S_BUS);
    wb_we_o   = we_q;
    wb_adr_o  = adr_q;
    wb_dat_o  = dat_q;
    rsp_dat   = rsp_dat_q;
    rsp_err   = rsp_err_q;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            we_q    <= cmd_we;
            adr_q   <= cmd_adr;
            dat_q   <= cmd_dat;
            tmo_cnt <= '0;
          end
        end
        S_BUS: begin
          if (bus_ack) begin
            we_q      <= 1'b0;
            rsp_dat_q <= we_q ? 8'h00 : wb_dat_i;
            rsp_err_q <= 1'b0;
          end else if (bus_tmo) begin
            we_q      <= 1'b0;
            rsp_dat_q <= ERR_DATA;
            rsp_err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WB_CMD_MASTER_STATS_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                          err_count <= '0;
    else if (bus_tmo && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: latency-programmable Wishbone slave plus a transaction-level
// reference model (register array, expected stb length, expected response).
module tb_wb_cmd_master;

  localparam int         T   = 15;
  localparam logic [7:0] ERR = 8'hFF;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_we = 1'b0;
  logic [4:0] cmd_adr = '0;
  logic [7:0] cmd_dat = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_dat;
  logic       rsp_err;
  logic       wb_cyc_o, wb_stb_o, wb_we_o;
  logic [4:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;
`ifdef WB_CMD_MASTER_STATS_EN
  logic [7:0] err_count;
  int         exp_errs = 0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_cmd_master #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERR)) dut (
`ifdef WB_CMD_MASTER_STATS_EN
    .err_count(err_count),
`endif
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 29 + 5);
  endfunction

  // Slave: ack is registered from stb and first visible in stb cycle ack_cycle (0 = never);
  // like the real register blocks it keeps ack high for one cycle after stb falls.
  int         ack_cycle = 0;
  int         stb_seen;
  logic [7:0] smem [32];

  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_i <= 1'b0;
      stb_seen <= 0;
      for (int i = 0; i < 32; i++) smem[i] <= init_val(i);
    end else begin
      stb_seen <= wb_stb_o ? stb_seen + 1 : 0;
      wb_ack_i <= wb_stb_o && (ack_cycle != 0) && (stb_seen + 2 >= ack_cycle);
      if (wb_stb_o && wb_ack_i && wb_we_o) smem[wb_adr_o] <= wb_dat_o;
    end
  end

  assign wb_dat_i = smem[wb_adr_o];

  // Reference model: register contents as seen by a host issuing commands.
  logic [7:0] mmem [32];

  task automatic reset_model();
    for (int i = 0; i < 32; i++) mmem[i] = init_val(i);
`ifdef WB_CMD_MASTER_STATS_EN
    exp_errs = 0;
`endif
  endtask

  task automatic wait_rsp(output bit timed_out);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 400) begin
      @(negedge wb_clk_i);
      n++;
    end
    timed_out = (rsp_valid !== 1'b1);
  endtask

  // One full command: issue, watch the bus, check the response, hold it `hold` cycles, drain.
  // Starts and ends just after a falling edge with the DUT idle.
  task automatic run_cmd(input logic we, input logic [4:0] adr, input logic [7:0] dat,
                         input int ackc, input int hold, input string tag);
    bit         ok;
    int         exp_stb, stb_n, cyc, bus_bad;
    logic [7:0] exp_dat, r_dat;
    logic       exp_err, r_err, stable;

    ok      = (ackc >= 2 && ackc <= T);
    exp_stb = ok ? ackc : T;
    exp_err = !ok;
    exp_dat = !ok ? ERR : (we ? 8'h00 : mmem[adr]);
    if (ok && we) mmem[adr] = dat;
`ifdef WB_CMD_MASTER_STATS_EN
    if (!ok && exp_errs < 255) exp_errs++;
`endif
    ack_cycle = ackc;

    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before_cmd: got %b want 1", tag, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    cmd_we  = 1'($urandom);
    cmd_adr = 5'($urandom);
    cmd_dat = 8'($urandom);

    stb_n = 0; cyc = 0; bus_bad = 0;
    while (rsp_valid !== 1'b1 && cyc < 400) begin
      if (wb_stb_o === 1'b1) begin
        stb_n++;
        if ({wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o} !== {1'b1, we, adr, dat}) bus_bad++;
      end
      @(negedge wb_clk_i);
      cyc++;
    end

    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s rsp_timeout: no rsp_valid within %0d cycles", tag, cyc);
    end
    total++;
    if (stb_n != exp_stb) begin
      bad++;
      $display("FAIL %s stb_cycles: got %0d want %0d", tag, stb_n, exp_stb);
    end
    total++;
    if (bus_bad != 0) begin
      bad++;
      $display("FAIL %s bus_fields: %0d cycles with wrong cyc/we/adr/dat", tag, bus_bad);
    end
    total++;
    if (rsp_dat !== exp_dat || rsp_err !== exp_err) begin
      bad++;
      $display("FAIL %s response: got dat=%h err=%b want dat=%h err=%b",
               tag, rsp_dat, rsp_err, exp_dat, exp_err);
    end
    total++;
    if (cmd_ready !== 1'b0 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0) begin
      bad++;
      $display("FAIL %s rsp_state: got ready=%b cyc=%b stb=%b we=%b want 0000",
               tag, cmd_ready, wb_cyc_o, wb_stb_o, wb_we_o);
    end
`ifdef WB_CMD_MASTER_STATS_EN
    total++;
    if (err_count !== 8'(exp_errs)) begin
      bad++;
      $display("FAIL %s err_count: got %0d want %0d", tag, err_count, exp_errs);
    end
`endif

    r_dat = rsp_dat; r_err = rsp_err; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge wb_clk_i);
      if (rsp_valid !== 1'b1 || rsp_dat !== r_dat || rsp_err !== r_err || wb_cyc_o !== 1'b0)
        stable = 1'b0;
    end
    if (hold > 0) begin
      total++;
      if (!stable) begin
        bad++;
        $display("FAIL %s rsp_hold: response changed while rsp_ready=0 (stable=%b want 1)", tag, stable);
      end
    end

    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wb_cyc_o !== 1'b0) begin
      bad++;
      $display("FAIL %s drain: got valid=%b ready=%b cyc=%b want 0 1 0", tag, rsp_valid, cmd_ready, wb_cyc_o);
    end
    @(negedge wb_clk_i);
    total++;
    if (rsp_valid !== 1'b0 || wb_cyc_o !== 1'b0) begin
      bad++;
      $display("FAIL %s after_drain: got valid=%b cyc=%b want 0 0", tag, rsp_valid, wb_cyc_o);
    end
  endtask

  task automatic test_reset();
    #1 wb_rst_i = 1'b1;
    #2;
    reset_model();
    total++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_rsp_side: got ready=%b valid=%b err=%b dat=%h want 1 0 0 00",
               cmd_ready, rsp_valid, rsp_err, rsp_dat);
    end
    total++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_bus_side: got cyc=%b stb=%b we=%b adr=%h dat=%h want all 0",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o);
    end
`ifdef WB_CMD_MASTER_STATS_EN
    total++;
    if (err_count !== 8'h00) begin
      bad++;
      $display("FAIL reset_err_count: got %h want 00", err_count);
    end
`endif
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
  endtask

  task automatic test_write();
    run_cmd(1'b1, 5'd7, 8'h03, 2, 0, "write_basic");
  endtask

  task automatic test_read_linger();
    run_cmd(1'b1, 5'd2, 8'h05, 2, 0, "write_for_read");
    run_cmd(1'b0, 5'd2, 8'h00, 2, 0, "read_linger");
  endtask

  task automatic test_timeout();
    run_cmd(1'b0, 5'd9, 8'h00, 0, 0, "timeout_no_ack");
    run_cmd(1'b1, 5'd4, 8'h77, T + 1, 0, "timeout_late_ack");
  endtask

  task automatic test_ack_last();
    run_cmd(1'b0, 5'd7, 8'h00, T, 0, "ack_last_cycle");
  endtask

  task automatic test_backpressure();
    bit to;
    logic [7:0] r_dat, exp_dat;
    logic stable;

    exp_dat = mmem[11];
    ack_cycle = 3;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 5'd11; cmd_dat = 8'h00;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    wait_rsp(to);
    total++;
    if (to || rsp_dat !== exp_dat || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL bp_first_rsp: got timeout=%b dat=%h err=%b want 0 %h 0", to, rsp_dat, rsp_err, exp_dat);
    end
    r_dat = rsp_dat;

    // Offer the next command while the response is stalled.
    ack_cycle = 2;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 5'd20; cmd_dat = 8'hA6;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk_i);
      if (rsp_valid !== 1'b1 || rsp_dat !== r_dat || rsp_err !== 1'b0 ||
          cmd_ready !== 1'b0 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0)
        stable = 1'b0;
    end
    total++;
    if (!stable) begin
      bad++;
      $display("FAIL bp_stall: response or bus moved during stall (stable=%b want 1)", stable);
    end

    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || wb_stb_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_idle: got ready=%b valid=%b stb=%b want 1 0 0", cmd_ready, rsp_valid, wb_stb_o);
    end
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    total++;
    if (wb_stb_o !== 1'b1 || wb_we_o !== 1'b1 || wb_adr_o !== 5'd20 || wb_dat_o !== 8'hA6) begin
      bad++;
      $display("FAIL bp_next_stb: got stb=%b we=%b adr=%h dat=%h want 1 1 14 a6",
               wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o);
    end
    mmem[20] = 8'hA6;
    wait_rsp(to);
    total++;
    if (to || rsp_dat !== 8'h00 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL bp_next_rsp: got timeout=%b dat=%h err=%b want 0 00 0", to, rsp_dat, rsp_err);
    end
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    @(negedge wb_clk_i);
    run_cmd(1'b0, 5'd20, 8'h00, 2, 0, "bp_readback");
  endtask

  task automatic test_back_to_back();
    logic [8:0] seen;
    ack_cycle = 2;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 5'd3; cmd_dat = 8'h00;
    for (int i = 0; i < 9; i++) begin
      seen[i] = cmd_ready;
      if (i == 8) cmd_valid = 1'b0;
      else @(negedge wb_clk_i);
    end
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    total++;
    if (seen !== 9'b100010001) begin
      bad++;
      $display("FAIL back_to_back_spacing: cmd_ready history %b want 100010001", seen);
    end
  endtask

  task automatic test_reset_mid_bus();
    ack_cycle = 0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 5'd6; cmd_dat = 8'h5A;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    #1;
    total++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_bus: got cyc=%b stb=%b valid=%b ready=%b want 0 0 0 1",
               wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready);
    end
    reset_model();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: got valid=%b ready=%b want 0 1", rsp_valid, cmd_ready);
    end
    run_cmd(1'b1, 5'd6, 8'hC3, 2, 1, "post_reset_write");
    run_cmd(1'b0, 5'd6, 8'h00, 4, 0, "post_reset_read");
  endtask

  task automatic test_random();
    int ackc;
    for (int n = 0; n < 40; n++) begin
      ackc = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, T + 2));
      run_cmd(1'($urandom), 5'($urandom), 8'($urandom), ackc, int'($urandom_range(0, 3)), "random");
    end
  endtask

`ifdef WB_CMD_MASTER_STATS_EN
  task automatic test_stats_saturate();
    for (int n = 0; n < 300; n++) run_cmd(1'b0, 5'($urandom), 8'h00, 0, 0, "stats_timeout");
    total++;
    if (err_count !== 8'hFF) begin
      bad++;
      $display("FAIL stats_saturate: got %h want ff", err_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_linger();
    test_timeout();
    test_ack_last();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_bus();
    test_random();
`ifdef WB_CMD_MASTER_STATS_EN
    test_stats_saturate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Single-outstanding Wishbone initiator for the CPLD register bus (5-bit address, 8-bit data).
- Drives the same slaves that the system/config register blocks implement.
- Takes one command (read or write) on a valid/ready request port, runs a single classic Wishbone cycle with timeout, and returns read data or an error on a valid/ready response port.
- Sits between a host-side command decoder (SPI/UART/EPB bridge) and the internal Wishbone slave fabric.

Parameters:
- TIMEOUT_CYCLES, 15, maximum number of cycles stb is held waiting for ack; legal range 2..255.
- ERR_DATA, 8'hFF, value returned on rsp_dat when a cycle times out.

Ports:
- wb_clk_i  in  1  bus clock; all logic on rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request valid.
- cmd_ready  out  1  block can accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  5  target register address.
- cmd_dat  in  8  write data; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_dat  out  8  read data; 8'h00 for successful writes; ERR_DATA on timeout.
- rsp_err  out  1  1 = cycle timed out without ack.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe; always equal to wb_cyc_o.
- wb_we_o  out  1  Wishbone write enable.
- wb_adr_o  out  5  Wishbone address.
- wb_dat_o  out  8  Wishbone write data.
- wb_dat_i  in  8  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.

Behaviour:
- Reset (async, immediate, no clock needed):
  - State = IDLE.
  - cmd_ready = 1; rsp_valid = 0; rsp_err = 0; rsp_dat = 8'h00.
  - wb_cyc_o = wb_stb_o = wb_we_o = 0; wb_adr_o = 0; wb_dat_o = 0.
  - Timeout counter = 0.
- All outputs are registered; no combinational path from any input to any output.
- IDLE:
  - cmd_ready = 1.
  - On a clock edge with cmd_valid=1: latch cmd_we/adr/dat into wb_we_o/wb_adr_o/wb_dat_o, set cyc=stb=1, clear counter, go to BUS, drop cmd_ready.
  - The first stb cycle is therefore the cycle after acceptance.
- BUS:
  - cyc, stb, we, adr and dat are held constant.
  - wb_ack_i is sampled only in BUS; ack seen in any other state is ignored. Slaves register ack from stb, so ack lingers one cycle after stb falls and must not be treated as a response.
  - Ack on an edge: clear cyc/stb/we, rsp_dat = wb_dat_i for reads or 8'h00 for writes, rsp_err = 0, rsp_valid = 1, go to RSP.
  - Otherwise the counter increments. If no ack arrives on the cycle where counter == TIMEOUT_CYCLES-1: clear cyc/stb/we, rsp_dat = ERR_DATA, rsp_err = 1, rsp_valid = 1, go to RSP.
  - stb is therefore high for at most TIMEOUT_CYCLES cycles.
  - Ack on the final allowed cycle wins: success, not error.
- RSP:
  - rsp_valid, rsp_dat and rsp_err are held stable until rsp_ready=1 on an edge.
  - On that edge: rsp_valid = 0, cmd_ready = 1, go to IDLE.
  - cmd_valid is not accepted in RSP; cmd_ready = 0.
- Throughput:
  - Minimum command-to-command spacing is 4 cycles with an ack latency of 1 and rsp_ready held high.
  - At most one Wishbone cycle is outstanding at any time.
- Reset during BUS or RSP: the cycle is aborted, no response is produced, and cyc/stb fall immediately.

Optional Feature:
- Macro: WB_CMD_MASTER_STATS_EN.
- Defined:
  - Adds output port err_count [7:0]: a saturating count of timeouts.
  - Increments on each BUS→RSP transition with rsp_err=1 and sticks at 8'hFF.
  - Reset to 0 by wb_rst_i.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Write cmd_adr=7, cmd_dat=8'h03 to a slave whose ack is stb delayed 1 cycle -> cyc/stb high exactly 2 cycles with we=1, adr=7, dat=8'h03; then rsp_valid=1, rsp_err=0, rsp_dat=8'h00.
- Read cmd_adr=2 with the slave driving 8'h05 -> rsp_dat=8'h05, rsp_err=0; the lingering ack in the cycle after stb falls does not produce a second response or state change.
- Read with no ack, TIMEOUT_CYCLES=15 -> stb high exactly 15 cycles, then rsp_err=1, rsp_dat=8'hFF; with STATS_EN, err_count goes 0→1; after 300 timeouts, err_count=8'hFF.
- Ack arriving on stb cycle 15 with TIMEOUT_CYCLES=15 -> rsp_err=0, rsp_dat = slave data.
- Hold rsp_ready=0 for 10 cycles with cmd_valid=1 -> rsp_valid/rsp_dat/rsp_err stable, cmd_ready=0, no new bus cycle; raise rsp_ready -> IDLE next cycle, new command accepted, stb on the following cycle.
- Assert wb_rst_i mid-BUS, between clock edges -> cyc/stb go 0 without a clock edge, rsp_valid=0; after release, cmd_ready=1 and the next command completes normally.
